// File: rtl/mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_arb_pkg
// Shared types and default constants for the multiplier-sharing arbiter.
//   state_t      : arbiter FSM states (IDLE, START, BUSY, RESP)
//   DEF_NREQ     : default number of requesters
//   DEF_WIDTH    : default operand width (product is 2*WIDTH)
//   DEF_TIMEOUT  : default watchdog limit (only used with MUL_ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter_if
// Requester-side bundle of the multiplier-sharing arbiter.
//   req_valid/req_ready      : per-requester operand handshake (ready is one-hot)
//   req_a/req_b              : per-requester operands
//   resp_valid/resp_ready    : per-requester result handshake (valid is one-hot)
//   resp_product             : shared product bus, meaningful where resp_valid is high
//   resp_err                 : watchdog timeout flag accompanying resp_valid
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mul_share_arbiter_if #(
    parameter int NREQ  = mul_arb_pkg::DEF_NREQ,
    parameter int WIDTH = mul_arb_pkg::DEF_WIDTH
) ();

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][WIDTH-1:0]  req_a;
    logic [NREQ-1:0][WIDTH-1:0]  req_b;
    logic [NREQ-1:0]             resp_valid;
    logic [NREQ-1:0]             resp_ready;
    logic [2*WIDTH-1:0]          resp_product;
    logic                        resp_err;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_product, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_product, resp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: selects the first set bit of req starting
// at rr_ptr and searching upward, wrapping modulo NREQ.
//   req       in  NREQ  request vector
//   rr_ptr    in  IDXW  search start index
//   grant     out NREQ  one-hot grant (all zero when nothing requested)
//   grant_idx out IDXW  encoded grant index
//   grant_any out 1     some request was found
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_any
);

    logic [IDXW-1:0] cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDXW'((int'(rr_ptr) + i) % NREQ);
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign grant[gi] = grant_any && (grant_idx == IDXW'(gi));
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
// Shares one sequential multiplier between NREQ requesters. One operation is
// in flight at a time; requesters are granted in round-robin order, the
// multiplier's start/done/get_output handshake is sequenced, and the product
// is returned to the granted requester.
//   clk, reset      : clock, asynchronous active-low reset
//   bus (slave)     : requester handshakes, operands and shared result bus
//   mul_start       : one-cycle start pulse to the multiplier
//   mul_a, mul_b    : registered operands to the multiplier
//   mul_done        : multiplier result ready
//   mul_product     : multiplier result
//   mul_get_output  : one-cycle acknowledge that the result was taken
// Optional feature: define MUL_ARB_TIMEOUT_EN to add a BUSY watchdog that
// returns product 0 with resp_err=1 after TIMEOUT BUSY cycles without done.
// -----------------------------------------------------------------------------
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    mul_share_arbiter_if.slave  bus,
    output logic                mul_start,
    output logic [WIDTH-1:0]    mul_a,
    output logic [WIDTH-1:0]    mul_b,
    input  logic                mul_done,
    input  logic [2*WIDTH-1:0]  mul_product,
    output logic                mul_get_output
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("mul_share_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    state_t              state_reg, state_next;
    logic [IDXW-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IDXW-1:0]     grant_reg, grant_next;
    logic [WIDTH-1:0]    mul_a_reg, mul_a_next;
    logic [WIDTH-1:0]    mul_b_reg, mul_b_next;
    logic [2*WIDTH-1:0]  resp_product_reg, resp_product_next;

    logic [NREQ-1:0]     pick_onehot;
    logic [IDXW-1:0]     pick_idx;
    logic                pick_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] wd_cnt_reg, wd_cnt_next;
    logic            resp_err_reg, resp_err_next;
    logic            wd_expired;

    // The count holds the number of BUSY cycles already completed, so it
    // reaches TIMEOUT at the end of the current cycle when it equals TIMEOUT-1.
    assign wd_expired = (state_reg == BUSY) && (wd_cnt_reg == CNTW'(TIMEOUT - 1));

    always_comb begin
        wd_cnt_next   = wd_cnt_reg;
        resp_err_next = resp_err_reg;
        if (state_reg == START) begin
            wd_cnt_next   = '0;
            resp_err_next = 1'b0;
        end else if (state_reg == BUSY) begin
            wd_cnt_next   = wd_cnt_reg + CNTW'(1);
            resp_err_next = !mul_done && wd_expired;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg   <= '0;
            resp_err_reg <= 1'b0;
        end else begin
            wd_cnt_reg   <= wd_cnt_next;
            resp_err_reg <= resp_err_next;
        end
    end

    assign bus.resp_err = resp_err_reg && (state_reg == RESP);
`else
    assign bus.resp_err = 1'b0;
`endif

    always_comb begin
        state_next        = state_reg;
        rr_ptr_next       = rr_ptr_reg;
        grant_next        = grant_reg;
        mul_a_next        = mul_a_reg;
        mul_b_next        = mul_b_reg;
        resp_product_next = resp_product_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_next = pick_idx;
                    mul_a_next = bus.req_a[pick_idx];
                    mul_b_next = bus.req_b[pick_idx];
                    state_next = START;
                end
            end
            START: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (mul_done) begin
                    resp_product_next = mul_product;
                    state_next        = RESP;
                end
`ifdef MUL_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    resp_product_next = '0;
                    state_next        = RESP;
                end
`endif
            end
            RESP: begin
                if (bus.resp_ready[grant_reg]) begin
                    // Next search starts just past the requester just served.
                    rr_ptr_next = (grant_reg == IDXW'(NREQ - 1)) ? '0 : grant_reg + IDXW'(1);
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            rr_ptr_reg       <= '0;
            grant_reg        <= '0;
            mul_a_reg        <= '0;
            mul_b_reg        <= '0;
            resp_product_reg <= '0;
        end else begin
            state_reg        <= state_next;
            rr_ptr_reg       <= rr_ptr_next;
            grant_reg        <= grant_next;
            mul_a_reg        <= mul_a_next;
            mul_b_reg        <= mul_b_next;
            resp_product_reg <= resp_product_next;
        end
    end

    assign mul_start        = (state_reg == START);
    assign mul_get_output   = (state_reg == BUSY) && mul_done;
    assign mul_a            = mul_a_reg;
    assign mul_b            = mul_b_reg;
    assign bus.resp_product = resp_product_reg;

    // req_ready is combinational from req_valid, so it is also masked by the
    // reset input to keep every output low while reset is held.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_resp
        assign bus.req_ready[gi]  = reset && (state_reg == IDLE) && pick_onehot[gi];
        assign bus.resp_valid[gi] = (state_reg == RESP) && (grant_reg == IDXW'(gi));
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arbiter
// Self-checking bench for mul_share_arbiter (NREQ=4, WIDTH=16, TIMEOUT=64).
// A small multiplier model answers mul_start after a programmable delay.
// Expected grants come from a round-robin model; expected products are pushed
// to a scoreboard at acceptance and popped at the response handshake.
// -----------------------------------------------------------------------------
module tb_mul_share_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int PW      = 2 * WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              mul_start;
    logic [WIDTH-1:0]  mul_a;
    logic [WIDTH-1:0]  mul_b;
    logic              mul_done;
    logic [PW-1:0]     mul_product;
    logic              mul_get_output;

    mul_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    mul_share_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .mul_start      (mul_start),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_done       (mul_done),
        .mul_product    (mul_product),
        .mul_get_output (mul_get_output)
    );

    // ---------------- multiplier model ----------------
    // mul_delay = d >= 1: mul_done rises d cycles after the mul_start cycle.
    // mul_delay = 0: never answers.
    int               mul_delay = 1;
    logic             m_busy;
    int               m_cnt;
    logic [WIDTH-1:0] m_a, m_b;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            m_a         <= '0;
            m_b         <= '0;
            mul_done    <= 1'b0;
            mul_product <= '0;
        end else begin
            if (mul_get_output) mul_done <= 1'b0;
            if (mul_start) begin
                if (mul_delay == 1) begin
                    mul_done    <= 1'b1;
                    mul_product <= PW'(mul_a) * PW'(mul_b);
                end else if (mul_delay > 1) begin
                    m_busy <= 1'b1;
                    m_cnt  <= mul_delay - 1;
                    m_a    <= mul_a;
                    m_b    <= mul_b;
                end
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    mul_done    <= 1'b1;
                    mul_product <= PW'(m_a) * PW'(m_b);
                    m_busy      <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;
    int rr_model = 0;

    typedef struct {
        int          idx;
        logic [31:0] prod;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] a;
        logic [15:0] b;
        int          delay;   // multiplier latency, 0 = never answers
        int          bp;      // back-pressure cycles, -1 = resp_ready before RESP
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (ptr + i) % NREQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic run_txn(input vec_t v);
        int          g;
        logic [3:0]  oh;
        exp_t        e;
        int          cycles, starts, gets, bad_get, bad_rdy, exp_lat;
        g  = model_pick(v.mask, rr_model);
        oh = 4'b0001 << g;
        // Granted requester carries (a,b); the others carry distinct decoys.
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i] = (i == g) ? v.a : v.a + 16'(i * 7 + 3);
            bus.req_b[i] = (i == g) ? v.b : v.b ^ 16'(i * 85 + 1);
        end
        bus.req_valid = v.mask;
        mul_delay     = v.delay;
        #1;
        check("req_ready_grant", bus.req_ready, oh);
        e.idx  = g;
        e.prod = (v.delay == 0) ? 32'h0 : 32'(v.a) * 32'(v.b);
        e.err  = (v.delay == 0);
        sb.push_back(e);
        @(posedge clk); #1;
        if (v.bp < 0) bus.resp_ready = oh;
        check("mul_a", mul_a, v.a);
        check("mul_b", mul_b, v.b);
        cycles = 0; starts = 0; gets = 0; bad_get = 0; bad_rdy = 0;
        while (bus.resp_valid == '0 && cycles < 300) begin
            if (mul_start) starts++;
            if (mul_get_output) begin
                gets++;
                if (!mul_done) bad_get++;
            end
            if (bus.req_ready != '0) bad_rdy++;
            @(posedge clk); #1;
            cycles++;
        end
        if (bus.resp_valid == '0) begin
            check("resp_wait_expired", 0, 1);
            bus.req_valid  = '0;
            bus.resp_ready = '0;
            return;
        end
        exp_lat = (v.delay == 0) ? TIMEOUT + 1 : v.delay + 1;
        check("resp_latency", cycles, exp_lat);
        check("mul_start_pulses", starts, 1);
        check("get_output_pulses", gets, (v.delay == 0) ? 0 : 1);
        check("get_output_without_done", bad_get, 0);
        check("req_ready_while_busy", bad_rdy, 0);
        if (v.bp > 0) bus.resp_ready = ~oh;
        for (int k = 0; k < v.bp; k++) begin
            check("bp_resp_valid", bus.resp_valid, oh);
            check("bp_resp_product", bus.resp_product, e.prod);
            check("bp_req_ready", bus.req_ready, 4'b0000);
            @(posedge clk); #1;
        end
        bus.resp_ready = oh;
        #1;
        e = sb.pop_front();
        check("resp_valid", bus.resp_valid, 4'b0001 << e.idx);
        check("resp_product", bus.resp_product, e.prod);
        check("resp_err", bus.resp_err, e.err);
        @(posedge clk); #1;
        check("resp_release", bus.resp_valid, 4'b0000);
        bus.resp_ready = '0;
        bus.req_valid  = '0;
        rr_model = (g + 1) % NREQ;
        $display("txn %0d: mask=%b grant=%0d a=%h b=%h product=%h err=%0d lat=%0d bp=%0d",
                 txn_no, v.mask, g, v.a, v.b, e.prod, e.err, cycles, v.bp);
        txn_no++;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[11];

    initial begin
        vecs[0]  = '{4'b1111, 16'h1234, 16'h0011, 3,  0};
        vecs[1]  = '{4'b1111, 16'h0F0F, 16'h0033, 5,  0};
        vecs[2]  = '{4'b1111, 16'h7777, 16'h0002, 2,  0};
        vecs[3]  = '{4'b1111, 16'h00AA, 16'h0055, 4,  0};
        vecs[4]  = '{4'b1111, 16'h4321, 16'h0100, 3,  0};
        vecs[5]  = '{4'b0100, 16'h0003, 16'h0005, 16, 0};
        vecs[6]  = '{4'b1111, 16'h00FF, 16'h0101, 4,  0};
        vecs[7]  = '{4'b0001, 16'hFFFF, 16'hFFFF, 6,  0};
        vecs[8]  = '{4'b1001, 16'hABCD, 16'h1357, 3,  10};
        vecs[9]  = '{4'b0110, 16'h8000, 16'h0002, 1,  -1};
        vecs[10] = '{4'b0011, 16'h0101, 16'h0202, 2,  0};

        bus.req_valid  = '0;
        bus.resp_ready = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.req_ready, bus.resp_valid, mul_start, mul_get_output, bus.resp_err},
              '0);
        check("reset_regs", {mul_a, mul_b, bus.resp_product}, '0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_txn(vecs[i]);

`ifdef MUL_ARB_TIMEOUT_EN
        run_txn('{4'b0001, 16'h0007, 16'h0009, 0, 2});
`endif

        // Reset while BUSY: everything clears at once, search restarts at 0.
        mul_delay     = 50;
        bus.req_a[2]  = 16'h0042;
        bus.req_b[2]  = 16'h0024;
        bus.req_valid = 4'b0100;
        #1;
        check("pre_reset_grant", bus.req_ready, 4'b0001 << model_pick(4'b0100, rr_model));
        @(posedge clk); #1;
        bus.req_valid = 4'b1010;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_outputs",
              {bus.req_ready, bus.resp_valid, mul_start, mul_get_output, bus.resp_err},
              '0);
        check("midreset_regs", {mul_a, mul_b, bus.resp_product}, '0);
        @(posedge clk); #1;
        reset    = 1'b1;
        rr_model = 0;
        sb.delete();
        run_txn('{4'b1010, 16'h0011, 16'h0022, 3, 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Shares one sequential array multiplier between NREQ independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time in round-robin order, sequences the multiplier's start / done / get_output handshake, and returns the 2*WIDTH product to the granted requester through a per-requester response handshake. It sits between the client blocks and the multiplier datapath + controller pair.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 16: operand width. Product width is 2*WIDTH.
- TIMEOUT, 64: watchdog limit in cycles. Used only with MUL_ARB_TIMEOUT_EN.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_a, req_b  in  NREQ x WIDTH  operands per requester.
- req_ready  out  NREQ  one-hot acceptance.
- resp_valid  out  NREQ  one-hot result available.
- resp_ready  in  NREQ  requester consumes result.
- resp_product  out  2*WIDTH  shared result bus, meaningful where resp_valid is high.
- resp_err  out  1  timeout flag accompanying resp_valid.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a, mul_b  out  WIDTH  registered operands to the multiplier.
- mul_done  in  1  multiplier result ready.
- mul_product  in  2*WIDTH  multiplier result.
- mul_get_output  out  1  one-cycle acknowledge that the result was taken.

## Operation
- FSM states: IDLE, START, BUSY, RESP.
- **IDLE**
  - If any req_valid is high: grant g = first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle.
  - On that cycle: latch req_a[g] and req_b[g] into mul_a and mul_b, latch g into grant_q, go to START.
- **START**
  - mul_start=1 for exactly one cycle, then go to BUSY.
- **BUSY**
  - When mul_done=1: capture mul_product into resp_product, drive mul_get_output=1 in the same cycle, go to RESP.
- **RESP**
  - resp_valid[grant_q]=1 and held until resp_ready[grant_q]=1.
  - On that handshake: rr_ptr <= (grant_q+1) mod NREQ, go to IDLE.
- Only one operation is in flight at a time. req_ready stays low in every state except IDLE.
- Requests may drop req_valid before acceptance with no side effects.
- resp_ready on a non-granted index is ignored.
- Product is unsigned, 2*WIDTH bits, and passed through unmodified.
- Reset (any time, including mid-operation):
  - State = IDLE, rr_ptr = 0, grant_q = 0.
  - mul_a, mul_b, resp_product = 0.
  - All outputs = 0.
  - The multiplier shares the same reset, so an in-flight product is discarded.

## Timing
- Cycle 0: accept handshake.
- Cycle 1: mul_start.
- Cycle 2 onward: BUSY.
- If mul_done rises in cycle k, resp_valid is high from cycle k+1.
- Back-to-back: next accept is no earlier than the cycle after the response handshake.
- Simultaneous requests: resolved purely by rr_ptr, with no starvation. Each waiting requester is served within NREQ grants.
- mul_done already high on BUSY entry: taken that cycle.
- resp_ready high on RESP entry: handshake completes in the first RESP cycle.

## Configuration
- **MUL_ARB_TIMEOUT_EN defined**
  - A counter clears on BUSY entry and increments each BUSY cycle.
  - If it reaches TIMEOUT without mul_done: go to RESP with resp_product = 0 and resp_err = 1.
  - mul_get_output is not pulsed in this case.
- **Without the macro**
  - No counter. BUSY waits indefinitely.
  - resp_err is tied to 0.

## Structure
- Package mul_arb_pkg holds:
  - the state enum (state_t: IDLE, START, BUSY, RESP);
  - default WIDTH and NREQ constants.
- Sub-module rr_arbiter:
  - combinational round-robin picker;
  - inputs: req vector and rr_ptr;
  - outputs: one-hot grant and encoded index.
- The top level holds the FSM, the operand/result registers and the optional watchdog.

## Test plan
- Single request: req 2 sends a=0x0003, b=0x0005; multiplier done after 16 cycles -> mul_start pulses once; resp_valid[2] with product 0x0000000F; rr_ptr becomes 3.
- All four requesters valid from reset -> grants in order 0, 1, 2, 3, 0 with no index repeated before the others are served.
- Max operands: a=b=0xFFFF -> product 0xFFFE0001; mul_get_output high exactly one cycle, coincident with mul_done.
- Response back-pressure: hold resp_ready low for 10 cycles -> resp_valid and resp_product stable; req_ready all 0 throughout.
- Reset asserted while BUSY -> all outputs 0 immediately; the next request from requester 1 is granted with rr_ptr = 0 (search starts at 0).
- With MUL_ARB_TIMEOUT_EN and TIMEOUT=64, mul_done never asserted -> resp_valid after 64 BUSY cycles with resp_err=1 and resp_product=0.
